// File: rtl/aes_dec_pkg.sv
// Shared AES-128 decryption constants, FSM encoding and GF(2^8) helpers.
// The S-box is computed as a field inverse plus affine map so no 256-entry table is needed.
package aes_dec_pkg;
  localparam int         AES_NR     = 10;
  localparam int         NB         = 16;
  localparam int         NC         = 4;
  localparam logic [7:0] RCON_FIRST = 8'h01;
  localparam logic [7:0] RCON_LAST  = 8'h36;
  localparam logic [7:0] RCON_WRAP  = 8'h1b;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_KEXP = 2'd1, ST_ROUND = 2'd2} dec_st_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? RCON_WRAP : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [7:0] x;
    x = ginv(a);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox_f(input logic [7:0] a);
    return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction
endpackage

// File: rtl/aes_inv_mixw.sv
// InvMixColumns on one 32-bit column; row 0 byte sits at [31:24].
module aes_inv_mixw
  import aes_dec_pkg::*;
(
  input  logic [31:0] w_i,
  output logic [31:0] w_o
);
  // each output row is the {0e,0b,0d,09} circulant rotated by the row index
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign w_o[31-8*r -: 8] = gmul(w_i[31-8*r -: 8], 8'h0e)
                            ^ gmul(w_i[31-8*((r+1)%4) -: 8], 8'h0b)
                            ^ gmul(w_i[31-8*((r+2)%4) -: 8], 8'h0d)
                            ^ gmul(w_i[31-8*((r+3)%4) -: 8], 8'h09);
  end
endmodule

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, one byte.
module aes_inv_sbox
  import aes_dec_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  assign y_o = inv_sbox_f(a_i);
endmodule

// File: rtl/aes_key_inv_step.sv
// Backward AES-128 key-schedule step: round key n -> round key n-1, plus the rcon walk-back.
module aes_key_inv_step
  import aes_dec_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_o,
  output logic [7:0]   rcon_o
);
  logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3, rw, sw;

  assign {w0, w1, w2, w3} = key_i;
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign rw = {p3[23:0], p3[31:24]};
  for (genvar b = 0; b < 4; b++) begin : g_sb
    aes_sbox u_sb (.a_i(rw[8*b +: 8]), .y_o(sw[8*b +: 8]));
  end
  assign p0     = w0 ^ sw ^ {rcon_i, 24'h0};
  assign key_o  = {p0, p1, p2, p3};
  assign rcon_o = (rcon_i == RCON_WRAP) ? 8'h80 : {1'b0, rcon_i[7:1]};
endmodule

// File: rtl/aes_key_shedualing.sv
// Forward AES-128 key-schedule step: round key n -> round key n+1.
module aes_key_shedualing (
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_o
);
  logic [31:0] w0, w1, w2, w3, rw, sw, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_i;
  assign rw = {w3[23:0], w3[31:24]};
  for (genvar b = 0; b < 4; b++) begin : g_sb
    aes_sbox u_sb (.a_i(rw[8*b +: 8]), .y_o(sw[8*b +: 8]));
  end
  assign n0 = w0 ^ sw ^ {rcon_i, 24'h0};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign key_o = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte.
module aes_sbox
  import aes_dec_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  assign y_o = sbox_f(a_i);
endmodule

// File: rtl/aes_dec_top.sv
// Iterative AES-128 decryptor: 10 forward key steps to reach rk10, then 10 inverse rounds
// that unwind the schedule one round key per cycle.
module aes_dec_top
  import aes_dec_pkg::*;
(
  input  logic         clk,
  input  logic         nreset,
  input  logic         data_v_i,
  input  logic [127:0] data_i,
  input  logic [127:0] key_i,
  output logic         busy_o,
  output logic         res_v_o,
  output logic [127:0] res_o
);
  dec_st_e      st_q, st_d;
  logic [127:0] data_q, data_d, key_q, key_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         res_v_q, res_v_d;

  logic [127:0] fwd_key, rk, isb, imc;
  logic [7:0]   rcon_prev;

  aes_key_shedualing u_kfwd (.key_i(key_q), .rcon_i(rcon_q), .key_o(fwd_key));
  aes_key_inv_step   u_kinv (.key_i(key_q), .rcon_i(rcon_q), .key_o(rk), .rcon_o(rcon_prev));

  // InvShiftRows folded into the S-box input wiring: byte (r,c) takes byte (r,c-r)
  for (genvar k = 0; k < NB; k++) begin : g_byte
    localparam int R   = k % 4;
    localparam int C   = k / 4;
    localparam int SRC = 4 * ((C - R + 4) % 4) + R;
    aes_inv_sbox u_isb (.a_i(data_q[127-8*SRC -: 8]), .y_o(isb[127-8*k -: 8]));
  end

  for (genvar c = 0; c < NC; c++) begin : g_col
    aes_inv_mixw u_imc (.w_i(isb[127-32*c -: 32] ^ rk[127-32*c -: 32]), .w_o(imc[127-32*c -: 32]));
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      st_q    <= ST_IDLE;
      data_q  <= '0;
      key_q   <= '0;
      rcon_q  <= '0;
      cnt_q   <= '0;
      res_v_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      data_q  <= data_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      cnt_q   <= cnt_d;
      res_v_q <= res_v_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    data_d  = data_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    cnt_d   = cnt_q;
    res_v_d = 1'b0;
    unique case (st_q)
      ST_IDLE: if (data_v_i) begin
        st_d   = ST_KEXP;
        data_d = data_i;
        key_d  = key_i;
        rcon_d = RCON_FIRST;
        cnt_d  = '0;
      end
      ST_KEXP: begin
        key_d = fwd_key;
        if (cnt_q == 4'(AES_NR - 1)) begin
          // last forward step also applies the initial AddRoundKey with rk10
          st_d   = ST_ROUND;
          data_d = data_q ^ fwd_key;
          rcon_d = RCON_LAST;
        end else begin
          rcon_d = xtime(rcon_q);
          cnt_d  = cnt_q + 4'd1;
        end
      end
      ST_ROUND: begin
        if (cnt_q == '0) begin
          st_d    = ST_IDLE;
          data_d  = isb ^ rk;
          res_v_d = 1'b1;
        end else begin
          data_d = imc;
          key_d  = rk;
          rcon_d = rcon_prev;
          cnt_d  = cnt_q - 4'd1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (st_q != ST_IDLE);
    res_v_o = res_v_q;
    res_o   = data_q;
  end
endmodule

// File: doc/aes_dec_top.md
Name: aes_dec_top

Overview:
- Iterative AES-128 decryption core (FIPS-197 inverse cipher): one round per clock; the inverse counterpart of the team's iterative encryption core.
- Accepts a ciphertext and the cipher key (not the last round key).
- Derives round key 10 internally with a 10-cycle forward key-expansion phase, then runs 10 inverse rounds, unwinding the key schedule backwards.
- Sits next to aes_enc_top; reuses the existing aes_key_shedualing forward key step.

Parameters:
- None. AES-128 is fixed: 128-bit block, 128-bit key, 10 rounds.

Ports:
- clk  input  1  clock, rising edge.
- nreset  input  1  asynchronous active-low reset.
- data_v_i  input  1  start pulse; sampled only when busy_o=0.
- data_i  input  128  ciphertext; FIPS byte 0 at [127:120]; column c at [127-32c:96-32c].
- key_i  input  128  cipher key, same byte order as data_i.
- busy_o  output  1  high while a block is in flight; new starts are ignored.
- res_v_o  output  1  one-cycle pulse: plaintext valid on res_o.
- res_o  output  128  plaintext; holds its value until the next accepted start.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on nreset.
- Reset values (nreset=0, asynchronous): fsm=IDLE, busy_o=0, res_v_o=0, res_o/data_q=0, key_q=0, rcon_q=0, cnt=0.
- States: IDLE, KEXP, ROUND.
- IDLE, data_v_i=1 at edge T:
  - data_q<=data_i, key_q<=key_i, rcon_q<=8'h01, cnt<=0.
  - Go to KEXP; busy_o=1 from T onward (registered).
- KEXP, edges T+1..T+10:
  - key_q<=forward_step(key_q,rcon_q); rcon_q<=xtime(rcon_q); cnt++.
  - On the 10th step (cnt==9), instead: key_q<=rk10, data_q<=data_q^rk10, rcon_q<=8'h36, cnt<=9, go to ROUND.
- ROUND, edges T+11..T+19 (cnt 9..1):
  - rk = inv_step(key_q,rcon_q).
  - data_q<=InvMixColumns(InvSubBytes(InvShiftRows(data_q))^rk).
  - key_q<=rk; rcon_q<=inv_xtime(rcon_q); cnt--.
- ROUND, cnt==0 (edge T+20), final round:
  - data_q<=InvSubBytes(InvShiftRows(data_q))^rk0, with no InvMixColumns.
  - res_v_o<=1, busy_o<=0, go to IDLE.
- Latency: result visible, with res_v_o=1, for the single cycle after edge T+20, i.e. 20 cycles after the accepting edge.
- Throughput: 1 block per 20 cycles. A new start may be accepted in the res_v_o cycle, since busy_o is already 0; res_o then changes on that same edge.
- inv_xtime: 8'h1b->8'h80; otherwise r>>1. Sequence from 36: 36,1b,80,40,20,10,08,04,02,01.
- inv_step, key words w0..w3 -> previous key p0..p3:
  - p3=w3^w2, p2=w2^w1, p1=w1^w0.
  - p0=w0^SubWord(RotWord(p3))^{rcon,24'h0}.
- data_v_i while busy_o=1: ignored, with no effect on state or outputs.
- data_i and key_i are sampled only on the accepting edge; later changes have no effect.
- Reset mid-operation: everything returns to the reset values immediately; no res_v_o pulse is produced.
- res_v_o is never high for two consecutive cycles.

Decomposition:
- aes_dec_pkg holds constants:
  - AES_NR=10.
  - RCON_FIRST=8'h01, RCON_LAST=8'h36, RCON_WRAP=8'h1b.
  - State encoding for IDLE/KEXP/ROUND.
- Natural sub-module aes_key_inv_step, covering inv_step plus inv_xtime; it reuses aes_sbox for SubWord.
- Leaf functions aes_inv_sbox and aes_inv_mixw are instantiated 16x and 4x respectively.

Test Plan:
- FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> res_o 3243f6a8885a308d313198a2e0370734, with res_v_o exactly 20 cycles after start. Internal check: key_q=d014f9a8c9ee2589e13f0cc8b6630ca6 after KEXP.
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> res_o 00112233445566778899aabbccddeeff.
- Back-to-back: start C.1 in the res_v_o cycle of App.B -> both plaintexts correct; pulses 20 cycles apart; busy_o low for exactly one cycle in between.
- data_v_i held high with random data for the whole operation -> ignored while busy; result still App.B plaintext; the next block is accepted in the res_v_o cycle.
- nreset asserted at cycle 12 of an operation -> outputs zero asynchronously, no res_v_o. A fresh App.B start after release decrypts correctly.
- Loopback: 1000 random key/pt pairs through aes_enc_top then aes_dec_top -> res_o == original pt every time.
